// File: rtl/processor_pkg.sv
// rtl/processor_pkg.sv - shared widths and write-back result FIFO entry type
package processor_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;
  localparam int MASK_W     = 1 << REG_ADDR_W;

  typedef struct packed {
    logic                  valid;
    logic                  dead;
    logic [REG_ADDR_W-1:0] dst_reg;
    logic [DATA_W-1:0]     data;
  } fifo_entry_t;

  function automatic logic [MASK_W-1:0] reg_onehot(input logic [REG_ADDR_W-1:0] r);
    return MASK_W'(1) << r;
  endfunction

endpackage

// File: rtl/wb_port_arbiter_if.sv
// rtl/wb_port_arbiter_if.sv - pipeline, mult/div and register-file port bundle
interface wb_port_arbiter_if;
  import processor_pkg::*;

  logic                  regWriteW;
  logic                  memToRegW;
  logic [DATA_W-1:0]     readDataW;
  logic [DATA_W-1:0]     ALUOutW;
  logic [REG_ADDR_W-1:0] writeRegW;
  logic                  mdValid;
  logic [REG_ADDR_W-1:0] mdReg;
  logic [DATA_W-1:0]     mdData;
  logic                  mdReady;
  logic                  rfWe;
  logic [REG_ADDR_W-1:0] rfAddr;
  logic [DATA_W-1:0]     rfData;
  logic                  stallReq;
  logic [MASK_W-1:0]     pendingMask;

  modport master (
    output regWriteW, memToRegW, readDataW, ALUOutW, writeRegW,
    output mdValid, mdReg, mdData,
    input  mdReady, rfWe, rfAddr, rfData, stallReq, pendingMask
  );

  modport slave (
    input  regWriteW, memToRegW, readDataW, ALUOutW, writeRegW,
    input  mdValid, mdReg, mdData,
    output mdReady, rfWe, rfAddr, rfData, stallReq, pendingMask
  );

endinterface

// File: rtl/wb_result_fifo.sv
// rtl/wb_result_fifo.sv - buffered mult/div results with kill-by-register and pending mask
module wb_result_fifo
  import processor_pkg::*;
#(
  parameter int FIFO_DEPTH = 2,
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [REG_ADDR_W-1:0] push_reg,
  input  logic [DATA_W-1:0]     push_data,
  input  logic                  pop,
  input  logic                  kill_en,
  input  logic [REG_ADDR_W-1:0] kill_reg,
  output fifo_entry_t           head,
  output logic [CNT_W-1:0]      count,
  output logic [MASK_W-1:0]     mask
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST = PTR_W'(FIFO_DEPTH - 1);

  fifo_entry_t          mem_q [FIFO_DEPTH];
  fifo_entry_t          mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
  logic [PTR_W-1:0]     wr_ptr_d, rd_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [MASK_W-1:0]    mask_q, mask_d;

  // Pointers wrap explicitly so non-power-of-two depths stay in range
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  // Next storage state: kill first, then pop, then push so a fresh entry is never killed
  always_comb begin
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      mem_d[i] = mem_q[i];
      if (kill_en && mem_q[i].valid && (mem_q[i].dst_reg == kill_reg)) begin
        mem_d[i].dead = 1'b1;
      end
    end
    if (pop) begin
      mem_d[rd_ptr_q] = '0;
    end
    if (push) begin
      mem_d[wr_ptr_q].valid   = 1'b1;
      mem_d[wr_ptr_q].dead    = 1'b0;
      mem_d[wr_ptr_q].dst_reg = push_reg;
      mem_d[wr_ptr_q].data    = push_data;
    end
    wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
  end

  // Pending mask is derived from the next state so it lands one cycle after the event
  always_comb begin
    mask_d = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (mem_d[i].valid && !mem_d[i].dead) begin
        mask_d = mask_d | reg_onehot(mem_d[i].dst_reg);
      end
    end
  end

  // Storage, pointers, occupancy and mask registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      mask_q   <= '0;
    end else begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      mask_q   <= mask_d;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;
  assign mask  = mask_q;

endmodule

// File: rtl/wb_port_arbiter.sv
// rtl/wb_port_arbiter.sv - shares the register-file write port between WB stage and mult/div
module wb_port_arbiter
  import processor_pkg::*;
#(
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  wb_port_arbiter_if.slave    bus
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int ST_W  = $clog2(STARVE_LIMIT + 1);

  fifo_entry_t       head;
  logic [CNT_W-1:0]  count;
  logic              pipe_live;
  logic [DATA_W-1:0] pipe_data;
  logic              head_live;
  logic              push;
  logic              pop;
  logic [ST_W-1:0]   starve_q, starve_d;
  logic              stall_q, stall_d;

  assign pipe_live   = bus.regWriteW && (bus.writeRegW != '0);
  assign pipe_data   = bus.memToRegW ? bus.readDataW : bus.ALUOutW;
  assign head_live   = head.valid && !head.dead;
  assign bus.mdReady = (count < CNT_W'(FIFO_DEPTH));
  // Results for register 0 complete the handshake but are never stored
  assign push        = bus.mdValid && bus.mdReady && (bus.mdReg != '0);
  // Dead heads drain every cycle; live heads only when the pipeline leaves the port free
  assign pop         = head.valid && (head.dead || !pipe_live);

  wb_result_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_reg  (bus.mdReg),
    .push_data (bus.mdData),
    .pop       (pop),
    .kill_en   (pipe_live),
    .kill_reg  (bus.writeRegW),
    .head      (head),
    .count     (count),
    .mask      (bus.pendingMask)
  );

  // Write port ownership: pipeline first, then a live FIFO head, else idle zeros
  always_comb begin
    bus.rfWe   = 1'b0;
    bus.rfAddr = '0;
    bus.rfData = '0;
    if (pipe_live) begin
      bus.rfWe   = 1'b1;
      bus.rfAddr = bus.writeRegW;
      bus.rfData = pipe_data;
    end else if (head_live) begin
      bus.rfWe   = 1'b1;
      bus.rfAddr = head.dst_reg;
      bus.rfData = head.data;
    end
  end

  // Starvation count and stall request; stall holds until the buffer has drained
  always_comb begin
    starve_d = starve_q;
    if (!head.valid || pop) begin
      starve_d = '0;
    end else if (head_live && (starve_q != ST_W'(STARVE_LIMIT))) begin
      starve_d = starve_q + 1'b1;
    end
    stall_d = (starve_q == ST_W'(STARVE_LIMIT)) ||
              (count == CNT_W'(FIFO_DEPTH)) ||
              (stall_q && (count != '0));
  end

  // Starvation and stall registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_q <= '0;
      stall_q  <= 1'b0;
    end else begin
      starve_q <= starve_d;
      stall_q  <= stall_d;
    end
  end

  assign bus.stallReq = stall_q;

endmodule

// File: doc/wb_port_arbiter.md
WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

Interface
REQ-001 Parameter: FIFO_DEPTH, default 2, number of multi-cycle results held while waiting for the write port.
REQ-002 Parameter: STARVE_LIMIT, default 4, consecutive unserved cycles before a stall is requested.
REQ-003 Port: clk  in  1  sole clock; all state updates on posedge.
REQ-004 Port: rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 Port: regWriteW  in  1  pipeline WB-stage write enable.
REQ-006 Port: memToRegW  in  1  1 selects readDataW, 0 selects ALUOutW.
REQ-007 Port: readDataW  in  32  WB-stage load data.
REQ-008 Port: ALUOutW  in  32  WB-stage ALU result.
REQ-009 Port: writeRegW  in  5  WB-stage destination register.
REQ-010 Port: mdValid  in  1  mult/div unit result valid.
REQ-011 Port: mdReg  in  5  mult/div destination register.
REQ-012 Port: mdData  in  32  mult/div result.
REQ-013 Port: mdReady  out  1  arbiter accepts a result this cycle.
REQ-014 Port: rfWe, rfAddr, rfData  out  1/5/32  single register-file write port, combinational.
REQ-015 Port: stallReq  out  1  registered; hazard unit freezes IF..MEM and injects a bubble into MEM/WB.
REQ-016 Port: pendingMask  out  32  registered; bit r set while a live FIFO entry targets register r.

Function
REQ-017 Pipeline write is live when regWriteW=1 and writeRegW!=0; data = memToRegW ? readDataW : ALUOutW.
REQ-018 Writes to register 0 (either source) never reach the port; a FIFO entry with mdReg=0 is dropped at push.
REQ-019 A live pipeline write always owns the port that cycle: rfWe=1, rfAddr=writeRegW, rfData=selected data.
REQ-020 With no live pipeline write and a live FIFO head, head is written (rfWe=1) and popped same cycle.
REQ-021 Otherwise rfWe=0; rfAddr and rfData=0.
REQ-022 mdReady = (registered count < FIFO_DEPTH); a same-cycle pop does not raise mdReady.
REQ-023 Handshake mdValid&&mdReady pushes {mdReg, mdData}; minimum push-to-write latency is 1 cycle; no bypass.
REQ-024 WAW kill: a live pipeline write to register r marks every FIFO entry targeting r dead; dead heads pop without writing, at one per cycle, regardless of port ownership.
REQ-025 An entry pushed in the same cycle as a pipeline write to the same register is not killed (md result is younger).
REQ-026 Starvation counter increments each cycle a live head exists and is not written; clears on any pop or when empty; saturates at STARVE_LIMIT.
REQ-027 stallReq sets next cycle when counter reaches STARVE_LIMIT or count = FIFO_DEPTH; holds until FIFO is empty, then clears next cycle.
REQ-028 Push and pop in the same cycle leave count unchanged; FIFO order strict first-in first-out; pointers wrap modulo FIFO_DEPTH.
REQ-029 pendingMask updates on the cycle after any push, pop or kill.

Reset
REQ-030 While rst_n=0: FIFO empty, entries invalid, pointers 0, counter 0, stallReq=0, pendingMask=0, mdReady=1.
REQ-031 Reset mid-operation discards all buffered results without writing them; outputs reach reset values asynchronously.

Structure
REQ-032 processor_pkg holds REG_ADDR_W=5, DATA_W=32 and the FIFO entry type {valid, dead, reg, data}.
REQ-033 Storage is one sub-module, wb_result_fifo (push, pop, kill-by-register, count, mask); arbitration and starvation logic stay in wb_port_arbiter.

Verification
REQ-034 Pipeline writes r5=0x11 each cycle, no md traffic -> rfWe=1, rfAddr=5, rfData=0x11 every cycle; stallReq stays 0.
REQ-035 md push r7=0xABCD, pipeline idle -> next cycle rfWe=1, rfAddr=7, rfData=0xABCD; pendingMask bit 7 set then cleared.
REQ-036 md push r8, pipeline live every cycle -> stallReq=1 the cycle after the counter hits 4; after bubble r8 written; stallReq clears when empty.
REQ-037 Two md pushes without pops -> mdReady=0, stallReq=1; third mdValid held until a pop.
REQ-038 md entry r9 buffered, pipeline writes r9=0x5 -> entry killed, r9 never rewritten with md data, pendingMask bit 9 clears.
REQ-039 rst_n pulled low with two entries buffered -> FIFO empty, stallReq=0, pendingMask=0 immediately; no rfWe after release.
